// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter.
//   MODE_RR / MODE_FIXED : run-time arbitration mode encodings
//   arb_state_e          : grant state (IDLE, BUSY)
//   onehot()             : index -> one-hot vector (MAX_N bits wide)
package arb_pkg;

  localparam int unsigned MAX_N = 32;
  localparam int unsigned MAX_W = 5;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot of idx; all-zero when idx is outside the n-requester range.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_N) v[MAX_W'(idx)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_encoder_n.sv
// Combinational N:IDXW priority encoder with a found flag.
//   req     : request vector
//   idx_c   : index of the winning bit (0 when none)
//   found_c : high when any req bit is set
// HIGH_FIRST=1 picks the highest set bit, otherwise the lowest.
module prio_encoder_n #(
  parameter  int unsigned N          = 4,
  parameter  bit          HIGH_FIRST = 1'b0,
  localparam int unsigned IDXW       = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] idx_c,
  output logic            found_c
);

  // Scan toward the preferred end so the last hit seen is the winner.
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (HIGH_FIRST) begin
        if (req[i]) begin
          idx_c   = IDXW'(i);
          found_c = 1'b1;
        end
      end else begin
        if (req[int'(N) - 1 - i]) begin
          idx_c   = IDXW'(int'(N) - 1 - i);
          found_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-requester arbiter, round-robin or fixed (highest index) priority.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   mode       : 0 = round-robin, 1 = fixed priority
//   gnt        : registered one-hot grant
//   gnt_idx    : registered encoded grant index
//   gnt_valid  : registered, high when gnt is non-zero
// With LOCK=1 the holder keeps the grant while its req stays high.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  bit          LOCK = 1'b1,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  arb_state_e      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [N-1:0]    req_masked;
  logic [IDXW-1:0] idx_masked, idx_unmasked, idx_high;
  logic            fnd_masked, fnd_unmasked, fnd_high;
  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic            arb_event;

  // Only requesters strictly above the last winner are eligible first.
  always_comb begin
    req_masked = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_masked[i] = req[i] && (i > int'(ptr_q));
    end
  end

  prio_encoder_n #(.N(N), .HIGH_FIRST(1'b0)) u_enc_masked (
    .req(req_masked), .idx_c(idx_masked), .found_c(fnd_masked)
  );

  prio_encoder_n #(.N(N), .HIGH_FIRST(1'b0)) u_enc_unmasked (
    .req(req), .idx_c(idx_unmasked), .found_c(fnd_unmasked)
  );

  prio_encoder_n #(.N(N), .HIGH_FIRST(1'b1)) u_enc_high (
    .req(req), .idx_c(idx_high), .found_c(fnd_high)
  );

  // Winner selection and next-state logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    win_idx     = '0;
    win_found   = 1'b0;

    arb_event = (state_q == IDLE) || !LOCK || !req[gnt_idx_q];

    if (mode == MODE_FIXED) begin
      win_idx   = idx_high;
      win_found = fnd_high;
    end else if (fnd_masked) begin
      win_idx   = idx_masked;
      win_found = 1'b1;
    end else begin
      win_idx   = idx_unmasked;
      win_found = fnd_unmasked;
    end

    if (arb_event) begin
      if (win_found) begin
        state_d     = BUSY;
        gnt_d       = N'(onehot(32'(win_idx), N));
        gnt_idx_d   = win_idx;
        gnt_valid_d = 1'b1;
        ptr_d       = win_idx;
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= IDXW'(N - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench: u_nl re-arbitrates every cycle, u_lk holds the grant.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       mode = 1'b0;

  logic [3:0] nl_gnt, lk_gnt;
  logic [1:0] nl_idx, lk_idx;
  logic       nl_valid, lk_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(4), .LOCK(1'b0)) u_nl (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(nl_gnt), .gnt_idx(nl_idx), .gnt_valid(nl_valid)
  );

  rr_priority_arbiter #(.N(4), .LOCK(1'b1)) u_lk (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(lk_gnt), .gnt_idx(lk_idx), .gnt_valid(lk_valid)
  );

  // Observed vectors packed as {gnt, gnt_idx, gnt_valid}.
  wire [6:0] nl_obs = {nl_gnt, nl_idx, nl_valid};
  wire [6:0] lk_obs = {lk_gnt, lk_idx, lk_valid};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    mode  = 1'b0;
    step();
    step();
    n_cmp++;
    if (nl_obs !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_nl: got %b want %b", nl_obs, 7'b0000_00_0);
    end
    n_cmp++;
    if (lk_obs !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL reset_lk: got %b want %b", lk_obs, 7'b0000_00_0);
    end
    rst_n = 1'b1;
    req   = 4'b1000;
    step();
    n_cmp++;
    if (nl_obs !== 7'b1000_11_1) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", nl_obs, 7'b1000_11_1);
    end
  endtask

  // ptr is 3 on entry (last grant was index 3).
  task automatic test_rr_rotation();
    logic [6:0] exp_tab [5];
    exp_tab[0] = 7'b0001_00_1;
    exp_tab[1] = 7'b0010_01_1;
    exp_tab[2] = 7'b0100_10_1;
    exp_tab[3] = 7'b1000_11_1;
    exp_tab[4] = 7'b0001_00_1;
    req  = 4'b1111;
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (nl_obs !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL rr_rotation[%0d]: got %b want %b", i, nl_obs, exp_tab[i]);
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1;
    req  = 4'b0110;
    step();
    n_cmp++;
    if (nl_obs !== 7'b0100_10_1) begin
      n_fail++;
      $display("FAIL fixed_0110: got %b want %b", nl_obs, 7'b0100_10_1);
    end
    req = 4'b1110;
    step();
    n_cmp++;
    if (nl_obs !== 7'b1000_11_1) begin
      n_fail++;
      $display("FAIL fixed_1110: got %b want %b", nl_obs, 7'b1000_11_1);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (nl_obs !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL fixed_none: got %b want %b", nl_obs, 7'b0000_00_0);
    end
  endtask

  task automatic test_lock();
    do_reset();
    mode = 1'b0;
    req  = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      step();
      // Fixed mode would choose index 1 if the lock were ignored.
      mode = (i == 1 || i == 2) ? 1'b1 : 1'b0;
      n_cmp++;
      if (lk_obs !== 7'b0001_00_1) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: got %b want %b", i, lk_obs, 7'b0001_00_1);
      end
    end
    mode = 1'b0;
    req  = 4'b0010;
    step();
    n_cmp++;
    if (lk_obs !== 7'b0010_01_1) begin
      n_fail++;
      $display("FAIL lock_handover: got %b want %b", lk_obs, 7'b0010_01_1);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b0;
    req  = 4'b1000;
    step();
    req = 4'b1001;
    step();
    n_cmp++;
    if (nl_obs !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL wrap_1001: got %b want %b", nl_obs, 7'b0001_00_1);
    end
    req = 4'b0001;
    step();
    n_cmp++;
    if (nl_obs !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL wrap_sole: got %b want %b", nl_obs, 7'b0001_00_1);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (lk_obs !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL wrap_release: got %b want %b", lk_obs, 7'b0000_00_0);
    end
    req = 4'b0001;
    step();
    n_cmp++;
    if (lk_obs !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL wrap_regrant: got %b want %b", lk_obs, 7'b0001_00_1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b1;
    req  = 4'b0100;
    step();
    n_cmp++;
    if (lk_obs !== 7'b0100_10_1) begin
      n_fail++;
      $display("FAIL async_setup: got %b want %b", lk_obs, 7'b0100_10_1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (lk_obs !== 7'b0000_00_0) begin
      n_fail++;
      $display("FAIL async_clear: got %b want %b", lk_obs, 7'b0000_00_0);
    end
    #1;
    rst_n = 1'b1;
    mode  = 1'b0;
    req   = 4'b0101;
    step();
    n_cmp++;
    if (lk_obs !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL async_ptr_lk: got %b want %b", lk_obs, 7'b0001_00_1);
    end
    n_cmp++;
    if (nl_obs !== 7'b0001_00_1) begin
      n_fail++;
      $display("FAIL async_ptr_nl: got %b want %b", nl_obs, 7'b0001_00_1);
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed();
    test_lock();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
